// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Round-robin front end that shares one sequential signed multiplier
//   among NREQ requesters. One requester is granted at a time. Its
//   operands are captured and the multiplier is started. Stale ready
//   flags are masked for GUARD cycles, and the product is returned,
//   tagged with the requester index, over a valid/ready channel.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   req            per-requester request level (sampled only in IDLE)
//   req_a, req_b   packed operands, slice i belongs to requester i
//   req_ack        one-hot pulse: operands of requester cur_id captured
//   rsp_valid      response available (held until rsp_ready)
//   rsp_id         index of the requester owning the response
//   rsp_product    signed 2*NB-bit product, passed through unmodified
//   rsp_ready      consumer accepts the response
//   mul_start      one-cycle start pulse to the multiplier
//   mul_a, mul_b   operands to the multiplier, stable until next grant
//   mul_product    multiplier result
//   mul_ready      multiplier done flag
//   busy           high whenever the controller is not idle
module mult_share_arbiter #(
  parameter int NB    = 32,
  parameter int NREQ  = 4,
  parameter int GUARD = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*NB-1:0] req_a,
  input  logic [NREQ*NB-1:0] req_b,
  output logic [NREQ-1:0]    req_ack,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [2*NB-1:0]    rsp_product,
  input  logic               rsp_ready,
  output logic               mul_start,
  output logic [NB-1:0]      mul_a,
  output logic [NB-1:0]      mul_b,
  input  logic [2*NB-1:0]    mul_product,
  input  logic               mul_ready,
  output logic               busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_GUARD = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam int             GW         = $clog2(GUARD + 1);
  localparam logic [GW-1:0]  GUARD_LOAD = GW'(GUARD);
  localparam logic [GW-1:0]  GUARD_ONE  = GW'(1);

  logic [2:0]     state;
  logic [IDW-1:0] cur_id;
  logic [IDW-1:0] last_grant;
  logic [GW-1:0]  guard_cnt;

  logic           pick_valid;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] cand_id;
  logic [NB-1:0]  pick_a;
  logic [NB-1:0]  pick_b;

  // Round-robin pick: scan the requesters starting just after the last
  // one served and wrapping, so the most recently served requester comes
  // last. The first set bit found wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand_id    = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand_id = IDW'((int'(last_grant) + off) % NREQ);
      if (!pick_valid && req[cand_id]) begin
        pick_valid = 1'b1;
        pick_id    = cand_id;
      end
    end
  end

  // Operand mux for the picked requester. A compare loop is used instead
  // of a variable part-select so the mux stays a plain, width-clean tree.
  always_comb begin
    pick_a = '0;
    pick_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id == IDW'(i)) begin
        pick_a = req_a[i*NB +: NB];
        pick_b = req_b[i*NB +: NB];
      end
    end
  end

  // Main controller. The guard counter is loaded in ISSUE and counts the
  // GUARD cycles during which mul_ready may still show the previous
  // operation's (or a pre-reset) completion. It leaves GUARD on the cycle
  // where the counter steps from 1 to 0. The last_grant update happens
  // only at the response handshake, so an aborted operation never shifts
  // the round-robin order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cur_id      <= '0;
      last_grant  <= IDW'(NREQ - 1);
      mul_a       <= '0;
      mul_b       <= '0;
      guard_cnt   <= '0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            cur_id <= pick_id;
            mul_a  <= pick_a;
            mul_b  <= pick_b;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          guard_cnt <= GUARD_LOAD;
          state     <= ST_GUARD;
        end
        ST_GUARD: begin
          guard_cnt <= guard_cnt - GUARD_ONE;
          if (guard_cnt == GUARD_ONE) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mul_ready) begin
            rsp_product <= mul_product;
            rsp_id      <= cur_id;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            last_grant <= cur_id;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs. They are derived from registered state only,
  // so all of them drop to zero as soon as reset is asserted.
  always_comb begin
    req_ack = '0;
    if (state == ST_ISSUE) begin
      req_ack[cur_id] = 1'b1;
    end
  end

  assign mul_start = (state == ST_ISSUE);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//   Self-checking bench for mult_share_arbiter. A small behavioural
//   multiplier sits behind the arbiter. It keeps its ready flag high
//   between operations and only drops it one cycle after a new start, so
//   a stale completion is visible during the guard window. Requesters
//   drop req after seeing their ack unless they are marked in hold.
module tb_mult_share_arbiter;

  localparam int NB    = 32;
  localparam int NREQ  = 4;
  localparam int GUARD = 2;
  localparam int IDW   = 2;
  localparam int LAT   = 6;

  typedef struct {
    logic [IDW-1:0]  id;
    logic [NB-1:0]   a;
    logic [NB-1:0]   b;
    logic [2*NB-1:0] exp;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*NB-1:0] req_a = '0;
  logic [NREQ*NB-1:0] req_b = '0;
  logic [NREQ-1:0]    req_ack;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [2*NB-1:0]    rsp_product;
  logic               rsp_ready = 1'b1;
  logic               mul_start;
  logic [NB-1:0]      mul_a;
  logic [NB-1:0]      mul_b;
  logic [2*NB-1:0]    mul_product;
  logic               mul_ready;
  logic               busy;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;
  int start_cnt = 0;
  int ack_ids[$];
  int rsp_ids[$];
  logic [2*NB-1:0] rsp_prods[$];
  logic [NREQ-1:0] hold = '0;
  logic prev_ack_any = 1'b0;

  vec_t vecs[5];
  vec_t rst_vec;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NB(NB), .NREQ(NREQ), .GUARD(GUARD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_a(req_a), .req_b(req_b), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .rsp_ready(rsp_ready),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_ready(mul_ready),
    .busy(busy)
  );

  // Behavioural multiplier. It powers up with a stale ready and a junk
  // product, ignores the arbiter's reset, and keeps ready high after
  // finishing until one cycle after the next start.
  logic [NB-1:0]   m_a = '0;
  logic [NB-1:0]   m_b = '0;
  logic [2*NB-1:0] m_prod = 64'h0BAD_0BAD_0BAD_0BAD;
  logic            m_ready = 1'b1;
  logic            m_clr = 1'b0;
  int              m_lat = 0;

  always @(posedge clk) begin
    if (mul_start) begin
      m_a   <= mul_a;
      m_b   <= mul_b;
      m_lat <= LAT;
      m_clr <= 1'b1;
    end else begin
      if (m_clr) begin
        m_ready <= 1'b0;
        m_clr   <= 1'b0;
      end
      if (m_lat > 0) begin
        m_lat <= m_lat - 1;
        if (m_lat == 1) begin
          m_ready <= 1'b1;
          m_prod  <= $signed(m_a) * $signed(m_b);
        end
      end
    end
  end

  assign mul_product = m_prod;
  assign mul_ready   = m_ready;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // One clock cycle, observed at the falling edge. Logs acks, starts and
  // accepted responses, and drops req for acked requesters that are not
  // held.
  task automatic stepCycle();
    @(negedge clk);
    if (req_ack != '0) begin
      checks++;
      if (!$onehot(req_ack) || prev_ack_any) begin
        failures++;
        $display("[TB] FAIL ack_pulse: got req_ack=%b prev_ack=%0b, expected one-hot single pulse",
                 req_ack, prev_ack_any);
      end
      ack_cnt++;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i]) begin
          ack_ids.push_back(i);
          if (!hold[i]) req[i] = 1'b0;
        end
      end
    end
    prev_ack_any = (req_ack != '0);
    if (mul_start) start_cnt++;
    if (rsp_valid && rsp_ready) begin
      rsp_ids.push_back(int'(rsp_id));
      rsp_prods.push_back(rsp_product);
    end
  endtask

  task automatic waitResponses(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (rsp_ids.size() < target && n < budget) begin
      stepCycle();
      n++;
    end
    checks++;
    if (rsp_ids.size() < target) begin
      failures++;
      $display("[TB] FAIL %s_timeout: got %0d responses, expected %0d", name, rsp_ids.size(), target);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_a[v.id*NB +: NB] = v.a;
    req_b[v.id*NB +: NB] = v.b;
    req[v.id] = 1'b1;
  endtask

  task automatic runVector(input vec_t v, input string name);
    int base_rsp, base_ack, base_start;
    base_rsp   = rsp_ids.size();
    base_ack   = ack_cnt;
    base_start = start_cnt;
    applyStimulus(v);
    waitResponses(base_rsp + 1, 100, name);
    if (rsp_ids.size() > base_rsp) begin
      checkOutput({name, "_id"}, 64'(rsp_ids[base_rsp]), 64'(v.id));
      checkOutput({name, "_product"}, rsp_prods[base_rsp], v.exp);
    end
    checkOutput({name, "_acks"}, 64'(ack_cnt - base_ack), 64'd1);
    checkOutput({name, "_starts"}, 64'(start_cnt - base_start), 64'd1);
    if (ack_ids.size() > 0) begin
      checkOutput({name, "_ack_id"}, 64'(ack_ids[ack_ids.size()-1]), 64'(v.id));
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    checkOutput({name, "_busy"}, 64'(busy), 64'd0);
    checkOutput({name, "_mul_start"}, 64'(mul_start), 64'd0);
    checkOutput({name, "_req_ack"}, 64'(req_ack), 64'd0);
    checkOutput({name, "_mul_a"}, 64'(mul_a), 64'd0);
    checkOutput({name, "_mul_b"}, 64'(mul_b), 64'd0);
    checkOutput({name, "_rsp_id"}, 64'(rsp_id), 64'd0);
    checkOutput({name, "_rsp_product"}, rsp_product, 64'd0);
  endtask

  initial begin
    int base, base_ack, base_start, n;
    logic saw_valid;

    vecs[0] = '{id: 2'd0, a: 32'd3,         b: 32'hFFFF_FFFB, exp: 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[1] = '{id: 2'd1, a: 32'h8000_0000, b: 32'h8000_0000, exp: 64'h4000_0000_0000_0000};
    vecs[2] = '{id: 2'd2, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 64'h0000_0000_0000_0001};
    vecs[3] = '{id: 2'd3, a: 32'h7FFF_FFFF, b: 32'h8000_0000, exp: 64'hC000_0000_8000_0000};
    vecs[4] = '{id: 2'd3, a: 32'hFFFF_FFF9, b: 32'd9,         exp: 64'hFFFF_FFFF_FFFF_FFC1};
    rst_vec = '{id: 2'd1, a: 32'd7,         b: 32'd6,         exp: 64'd42};

    $display("[TB] reset state");
    repeat (3) stepCycle();
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (2) stepCycle();
    checkOutput("idle_busy", 64'(busy), 64'd0);

    $display("[TB] directed vectors");
    for (int k = 0; k < 5; k++) begin
      runVector(vecs[k], $sformatf("vec%0d", k));
      stepCycle();
    end

    $display("[TB] four simultaneous requesters");
    base = rsp_ids.size();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*NB +: NB] = NB'(i + 1);
      req_b[i*NB +: NB] = 32'd10;
    end
    req = 4'hF;
    waitResponses(base + 4, 200, "all4");
    for (int k = 0; k < 4; k++) begin
      if (rsp_ids.size() > base + k) begin
        checkOutput($sformatf("all4_id%0d", k), 64'(rsp_ids[base+k]), 64'(k));
        checkOutput($sformatf("all4_product%0d", k), rsp_prods[base+k], 64'(10 * (k + 1)));
      end
    end
    stepCycle();

    $display("[TB] fairness between requesters 0 and 2");
    base = rsp_ids.size();
    req_a[0*NB +: NB] = 32'd5;
    req_b[0*NB +: NB] = 32'd5;
    req_a[2*NB +: NB] = 32'hFFFF_FFFE;
    req_b[2*NB +: NB] = 32'd4;
    hold = 4'b0101;
    req  = 4'b0101;
    n = 0;
    while (rsp_ids.size() < base + 8 && n < 400) begin
      stepCycle();
      n++;
      if (rsp_ids.size() >= base + 8) begin
        req  = '0;
        hold = '0;
      end
    end
    req  = '0;
    hold = '0;
    checkOutput("fair_count", 64'(rsp_ids.size() - base), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (rsp_ids.size() > base + k) begin
        checkOutput($sformatf("fair_id%0d", k), 64'(rsp_ids[base+k]), (k % 2 == 0) ? 64'd0 : 64'd2);
        checkOutput($sformatf("fair_product%0d", k), rsp_prods[base+k],
                    (k % 2 == 0) ? 64'd25 : 64'hFFFF_FFFF_FFFF_FFF8);
      end
    end
    repeat (3) stepCycle();
    checkOutput("fair_idle", 64'(busy), 64'd0);

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    req_a[3*NB +: NB] = 32'd11;
    req_b[3*NB +: NB] = 32'd3;
    req[3] = 1'b1;
    n = 0;
    while (!rsp_valid && n < 100) begin
      stepCycle();
      n++;
    end
    checkOutput("bp_valid_rise", 64'(rsp_valid), 64'd1);
    req_a[1*NB +: NB] = 32'hFFFF_FFFC;
    req_b[1*NB +: NB] = 32'hFFFF_FFFC;
    req[1] = 1'b1;
    base_ack   = ack_cnt;
    base_start = start_cnt;
    for (int k = 0; k < 10; k++) begin
      stepCycle();
      checkOutput($sformatf("bp_valid%0d", k), 64'(rsp_valid), 64'd1);
      checkOutput($sformatf("bp_id%0d", k), 64'(rsp_id), 64'd3);
      checkOutput($sformatf("bp_product%0d", k), rsp_product, 64'd33);
    end
    checkOutput("bp_no_ack", 64'(ack_cnt - base_ack), 64'd0);
    checkOutput("bp_no_start", 64'(start_cnt - base_start), 64'd0);
    rsp_ready = 1'b1;
    base = rsp_ids.size();
    n = 0;
    while (ack_cnt == base_ack && n < 2) begin
      stepCycle();
      n++;
    end
    checkOutput("bp_release_acks", 64'(ack_cnt - base_ack), 64'd1);
    if (ack_ids.size() > 0) begin
      checkOutput("bp_release_ack_id", 64'(ack_ids[ack_ids.size()-1]), 64'd1);
    end
    waitResponses(base + 1, 100, "bp_next");
    if (rsp_ids.size() > base) begin
      checkOutput("bp_next_id", 64'(rsp_ids[base]), 64'd1);
      checkOutput("bp_next_product", rsp_prods[base], 64'd16);
    end
    stepCycle();

    $display("[TB] reset during WAIT");
    base_start = start_cnt;
    req_a[2*NB +: NB] = 32'd100;
    req_b[2*NB +: NB] = 32'd3;
    req[2] = 1'b1;
    n = 0;
    while (start_cnt == base_start && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("abort_started", 64'(start_cnt - base_start), 64'd1);
    repeat (3) stepCycle();
    checkOutput("abort_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkAllZero("abort");
    base = rsp_ids.size();
    repeat (2) stepCycle();
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      stepCycle();
      if (rsp_valid) saw_valid = 1'b1;
    end
    checkOutput("abort_no_valid", 64'(saw_valid), 64'd0);
    checkOutput("abort_no_response", 64'(rsp_ids.size() - base), 64'd0);
    runVector(rst_vec, "after_reset");
    stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
